reg_serial_tx: RTL and testbench
================================

Name: reg_serial_tx

Overview:
Reads a 16-bit word out of a loadable parallel register and sends it as an asynchronous serial frame: start bit, data LSB-first, stop bit. It is the read/transmit end of the register path. Upstream logic presents a word with a load strobe. The block captures the word, serializes it at a fixed number of clocks per bit, and signals completion.

Parameters:
WIDTH, 16, data word width in bits (>=2)
BIT_TICKS, 4, clock cycles per serial bit (>=1; 1 must work)

Ports:
clk  input  1  system clock; all state updates on rising edge
reset  input  1  synchronous, active-high reset
d  input  WIDTH  parallel word to transmit
ld  input  1  load strobe; accepted only when ready=1
ready  output  1  high when idle and able to accept ld
busy  output  1  high while a frame is in progress (inverse of ready)
tx  output  1  serial line; idles high
done  output  1  one-cycle pulse when a frame completes

Behaviour:
- Reset (synchronous, active-high, priority over everything):
  - state=IDLE, tx=1, ready=1, busy=0, done=0.
  - Shift register and both counters cleared.
  - Reset mid-frame aborts the frame immediately at that edge; no done pulse.
- All outputs are registered. tx is driven from a flop, never from combinational decode.
- FSM states: IDLE, START, DATA, STOP.
- IDLE:
  - tx=1.
  - On an edge with ld=1, capture d into the shift register, go to START, clear the tick and bit counters.
  - ld=0 means stay in IDLE.
- START: tx=0 for BIT_TICKS cycles, then go to DATA.
- DATA:
  - tx=shift[0] for BIT_TICKS cycles, then shift right by 1 and increment the bit counter.
  - After WIDTH bits, go to STOP.
- STOP: tx=1 for BIT_TICKS cycles, then go to IDLE.
- Timing:
  - If ld is accepted at edge E, tx falls after E.
  - The frame occupies exactly (WIDTH+2)*BIT_TICKS cycles.
  - At edge E+(WIDTH+2)*BIT_TICKS: ready=1, busy=0, done=1 for exactly that one cycle.
- Handshake:
  - ld while busy=1 is ignored entirely. No queuing, no effect on the current frame.
  - ld in the cycle where done=1 (ready=1) is accepted. Back-to-back frames have no idle gap.
  - d is sampled only at the accept edge; later changes to d do not affect the frame.
- Counters:
  - Tick counter width is clog2(BIT_TICKS), minimum 1 bit. It wraps from BIT_TICKS-1 to 0 at each bit boundary.
  - Bit counter width is clog2(WIDTH+1). It never exceeds WIDTH.
- Unused or illegal state encodings recover to IDLE with tx=1 on the next edge.

Test Plan:
- Reset then idle, with ld=0 for 20 cycles -> tx=1, ready=1, busy=0, done=0 throughout.
- WIDTH=16, BIT_TICKS=4, d=16'hA5C3, ld pulsed one cycle at edge E:
  - Sampling tx at the centre of each 4-cycle bit gives 0, then 1,1,0,0,0,0,1,1,1,0,1,0,0,1,0,1, then 1.
  - done=1 at E+72 only; busy=1 from E to E+71.
- During that frame, ld=1 with d=16'hFFFF at E+10 -> the frame is unchanged; no second frame follows.
- Back-to-back: ld held high continuously with d=16'h0001, then 16'h8000 presented at E+72:
  - Second start bit begins immediately after E+72 with no gap.
  - done pulses at E+72 and E+144.
- Reset asserted at E+30 mid-DATA -> tx=1, ready=1, busy=0 after that edge; no done pulse.
  - A new ld at E+32 transmits a full correct frame.
- BIT_TICKS=1, d=16'h00FF -> each bit lasts 1 cycle; the frame is 18 cycles; tx sequence is 0, eight 1s, eight 0s, 1.

Source files
------------

// File: rtl/reg_serial_tx.sv
// Parallel-load register serializer: start bit, WIDTH data bits LSB-first, stop bit, BIT_TICKS clocks each.
// Every output is a flop; a new word may be loaded on the same edge that ends the stop bit, so frames can run back-to-back.
module reg_serial_tx #(
    parameter int WIDTH     = 16,
    parameter int BIT_TICKS = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] d,
    input  logic             ld,
    output logic             ready,
    output logic             busy,
    output logic             tx,
    output logic             done
);

    localparam int TW = (BIT_TICKS > 1) ? $clog2(BIT_TICKS) : 1;
    localparam int BW = $clog2(WIDTH + 1);
    localparam logic [TW-1:0] TICK_LAST = TW'(BIT_TICKS - 1);
    localparam logic [BW-1:0] BIT_LAST  = BW'(WIDTH - 1);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    state_t           state, state_nxt;
    logic [TW-1:0]    tick, tick_nxt;
    logic [BW-1:0]    bit_cnt, bit_nxt;
    logic [WIDTH-1:0] shift, shift_nxt;
    logic             tx_nxt, ready_nxt, busy_nxt, done_nxt;
    logic             tick_end, accept;

    assign tick_end = (tick == TICK_LAST);
    // Loads are taken when idle, or on the final tick of the stop bit to avoid an idle gap.
    assign accept   = ld && ((state == IDLE) || ((state == STOP) && tick_end));

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= IDLE;
            tick    <= '0;
            bit_cnt <= '0;
            shift   <= '0;
            tx      <= 1'b1;
            ready   <= 1'b1;
            busy    <= 1'b0;
            done    <= 1'b0;
        end else begin
            state   <= state_nxt;
            tick    <= tick_nxt;
            bit_cnt <= bit_nxt;
            shift   <= shift_nxt;
            tx      <= tx_nxt;
            ready   <= ready_nxt;
            busy    <= busy_nxt;
            done    <= done_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (ld) state_nxt = START;
            START:   if (tick_end) state_nxt = DATA;
            DATA:    if (tick_end && (bit_cnt == BIT_LAST)) state_nxt = STOP;
            STOP:    if (tick_end) state_nxt = ld ? START : IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        tick_nxt  = tick;
        bit_nxt   = bit_cnt;
        shift_nxt = shift;
        if (accept) begin
            shift_nxt = d;
            tick_nxt  = '0;
            bit_nxt   = '0;
        end else if (state != IDLE) begin
            tick_nxt = tick_end ? '0 : tick + TW'(1);
            if ((state == DATA) && tick_end) begin
                shift_nxt = shift >> 1;
                bit_nxt   = bit_cnt + BW'(1);
            end
        end

        // tx is precomputed from the next state so the line comes straight off a flop.
        case (state_nxt)
            START:   tx_nxt = 1'b0;
            DATA:    tx_nxt = shift_nxt[0];
            default: tx_nxt = 1'b1;
        endcase
        ready_nxt = (state_nxt == IDLE);
        busy_nxt  = (state_nxt != IDLE);
        done_nxt  = (state == STOP) && tick_end;
    end

endmodule

// File: tb/tb_reg_serial_tx.sv
// Bench for reg_serial_tx: two instances (BIT_TICKS=4 and 1) on shared stimulus, checked each cycle
// against a frame-position model, plus literal expectations for the directed scenarios.
module tb_reg_serial_tx;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [15:0] d = 16'h0;
    logic        ld = 1'b0;
    logic        ready4, busy4, tx4, done4;
    logic        ready1, busy1, tx1, done1;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc = 0;
    bit chk_en = 1'b0;

    always #5 clk = ~clk;

    reg_serial_tx #(.WIDTH(16), .BIT_TICKS(4)) dut4 (
        .clk(clk), .reset(reset), .d(d), .ld(ld),
        .ready(ready4), .busy(busy4), .tx(tx4), .done(done4)
    );

    reg_serial_tx #(.WIDTH(16), .BIT_TICKS(1)) dut1 (
        .clk(clk), .reset(reset), .d(d), .ld(ld),
        .ready(ready1), .busy(busy1), .tx(tx1), .done(done1)
    );

    // Model: a frame is just "cycles elapsed since the accept edge" plus the captured word.
    typedef struct {
        bit          busy;
        int          c;
        logic [15:0] word;
        bit          done;
    } mdl_t;

    mdl_t m4 = '{busy: 1'b0, c: 0, word: 16'h0, done: 1'b0};
    mdl_t m1 = '{busy: 1'b0, c: 0, word: 16'h0, done: 1'b0};

    function automatic mdl_t step(input mdl_t m, input bit rst, input bit l,
                                  input logic [15:0] din, input int t);
        mdl_t r;
        int   n;
        r      = m;
        n      = 18 * t;
        r.done = 1'b0;
        if (rst) begin
            r.busy = 1'b0;
            r.c    = 0;
        end else if (m.busy) begin
            if (m.c == n - 1) begin
                r.done = 1'b1;
                if (l) begin
                    r.c    = 0;
                    r.word = din;
                end else begin
                    r.busy = 1'b0;
                end
            end else begin
                r.c = m.c + 1;
            end
        end else if (l) begin
            r.busy = 1'b1;
            r.c    = 0;
            r.word = din;
        end
        return r;
    endfunction

    function automatic logic exp_tx(input mdl_t m, input int t);
        int k;
        if (!m.busy) return 1'b1;
        k = m.c / t;
        if (k == 0) return 1'b0;
        if (k <= 16) return m.word[k-1];
        return 1'b1;
    endfunction

    task automatic check(input string name, input logic act, input logic exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %b, expected %b (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    always @(posedge clk) begin
        cyc <= cyc + 1;
        m4  <= step(m4, reset, ld, d, 4);
        m1  <= step(m1, reset, ld, d, 1);
    end

    always @(negedge clk) begin
        if (chk_en) begin
            check("m4_tx",    tx4,    exp_tx(m4, 4));
            check("m4_ready", ready4, !m4.busy);
            check("m4_busy",  busy4,  m4.busy);
            check("m4_done",  done4,  m4.done);
            check("m1_tx",    tx1,    exp_tx(m1, 1));
            check("m1_ready", ready1, !m1.busy);
            check("m1_busy",  busy1,  m1.busy);
            check("m1_done",  done1,  m1.done);
        end
    end

    bit seq [18] = '{0, 1, 1, 0, 0, 0, 0, 1, 1, 1, 0, 1, 0, 0, 1, 0, 1, 1};

    initial begin
        // Reset and idle.
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk_en = 1'b1;
        reset  = 1'b0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            check("idle_tx", tx4, 1'b1);
            check("idle_ready", ready4, 1'b1);
            check("idle_busy", busy4, 1'b0);
            check("idle_done", done4, 1'b0);
        end

        // Single A5C3 frame with an ignored load at E+10.
        d  = 16'hA5C3;
        ld = 1'b1;
        @(posedge clk);
        for (int k = 0; k <= 80; k++) begin
            @(negedge clk);
            ld = (k == 9);
            d  = (k == 9) ? 16'hFFFF : 16'hA5C3;
            if ((k % 4 == 2) && (k / 4 < 18)) check("a5c3_bit", tx4, seq[k/4]);
            check("a5c3_done", done4, k == 72);
            check("a5c3_busy", busy4, k < 72);
        end

        // Back-to-back frames with ld held high.
        d  = 16'h0001;
        ld = 1'b1;
        @(posedge clk);
        for (int k = 0; k <= 150; k++) begin
            @(negedge clk);
            if (k == 71) d = 16'h8000;
            if (k == 150) ld = 1'b0;
            check("b2b_done", done4, (k == 72) || (k == 144));
            if (k == 6)   check("b2b_f1_bit0", tx4, 1'b1);
            if (k == 10)  check("b2b_f1_bit1", tx4, 1'b0);
            if (k == 72)  check("b2b_nogap_tx", tx4, 1'b0);
            if (k == 72)  check("b2b_nogap_busy", busy4, 1'b1);
            if (k == 134) check("b2b_f2_bit14", tx4, 1'b0);
            if (k == 138) check("b2b_f2_bit15", tx4, 1'b1);
        end
        repeat (80) @(negedge clk);

        // Reset mid-DATA, then a fresh frame.
        d  = 16'($urandom);
        ld = 1'b1;
        @(posedge clk);
        for (int k = 0; k <= 110; k++) begin
            @(negedge clk);
            ld = 1'b0;
            if (k == 29) reset = 1'b1;
            if (k == 30) begin
                reset = 1'b0;
                check("abort_tx", tx4, 1'b1);
                check("abort_ready", ready4, 1'b1);
                check("abort_busy", busy4, 1'b0);
            end
            if (k == 31) begin
                ld = 1'b1;
                d  = 16'h3C5A;
            end
            if (k == 32)  check("reload_busy", busy4, 1'b1);
            if (k == 40)  check("reload_bit1", tx4, 1'b1);
            if (k >= 30)  check("abort_done", done4, k == 104);
        end

        // BIT_TICKS=1 frame of 00FF.
        @(negedge clk);
        d  = 16'h00FF;
        ld = 1'b1;
        @(posedge clk);
        for (int k = 0; k <= 20; k++) begin
            @(negedge clk);
            ld = 1'b0;
            if (k < 18) check("t1_tx", tx1, (k == 0) ? 1'b0 : (k <= 8) ? 1'b1 : (k <= 16) ? 1'b0 : 1'b1);
            check("t1_done", done1, k == 18);
        end
        repeat (80) @(negedge clk);

        // Randomized traffic, including occasional resets and sustained loads.
        for (int k = 0; k < 3000; k++) begin
            @(negedge clk);
            reset = ($urandom_range(0, 199) == 0);
            ld    = ($urandom_range(0, 3) == 0);
            d     = 16'($urandom);
        end
        @(negedge clk);
        ld    = 1'b0;
        reset = 1'b0;
        repeat (80) @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
